sad_sequencer: RTL

- Sits between the stereo line-buffer column stream and one `sad` disparity engine.
- Accepts one left/right kernel column at a time with a valid/ready handshake and issues it to the engine as a single-cycle valid. It holds off upstream while the engine is busy, then captures the engine's depth result.
- Suppresses results produced while the engine caches are still priming at the start of each row.
- Re-emits results with full-width pixel coordinates and a frame-done pulse.

---
 rtl/sad_pkg.sv | 18 +
 rtl/sad_seq_row_tracker.sv | 54 +++++
 rtl/sad_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD column sequencer.
package sad_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  // The engine caches need this many columns of a row before results are meaningful.
  function automatic int WARMUP_COLS(input int kernel_width, input int offset);
    return kernel_width + offset - 1;
  endfunction

endpackage

// File: rtl/sad_seq_row_tracker.sv
// Tracks the column index within the current row and flags warm-up and
// last-pixel-of-frame columns; all state updates only on an accept strobe.
module sad_seq_row_tracker
  import sad_pkg::*;
#(
  parameter int KERNEL_WIDTH = 3,
  parameter int OFFSET       = 10,
  parameter int H_ACTIVE     = 320,
  parameter int V_ACTIVE     = 240
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                i_accept,
  input  logic [HCOUNT_W-1:0] i_hcount,
  input  logic [VCOUNT_W-1:0] i_vcount,
  output logic                o_warmup,
  output logic                o_last_pix
);

  localparam int IDX_W = $clog2(H_ACTIVE + 1);
  localparam logic [IDX_W-1:0]    IDX_MAX = IDX_W'(H_ACTIVE);
  localparam logic [IDX_W-1:0]    WARMUP  = IDX_W'(WARMUP_COLS(KERNEL_WIDTH, OFFSET));
  localparam logic [HCOUNT_W-1:0] LAST_X  = HCOUNT_W'(H_ACTIVE - 1);
  localparam logic [VCOUNT_W-1:0] LAST_Y  = VCOUNT_W'(V_ACTIVE - 1);

  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_next_idx;
  logic [VCOUNT_W-1:0] r_last_row;

  // A new row starts on x == 0 or on any change of y, even mid-stream.
  always_comb begin
    w_next_idx = r_idx;
    if (i_hcount == '0 || i_vcount != r_last_row) begin
      w_next_idx = '0;
    end else if (r_idx != IDX_MAX) begin
      w_next_idx = r_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_idx      <= '0;
      r_last_row <= '0;
      o_warmup   <= 1'b0;
      o_last_pix <= 1'b0;
    end else if (i_accept) begin
      r_idx      <= w_next_idx;
      r_last_row <= i_vcount;
      o_warmup   <= (w_next_idx < WARMUP);
      o_last_pix <= (i_hcount == LAST_X) && (i_vcount == LAST_Y);
    end
  end

endmodule

// File: rtl/sad_sequencer.sv
// Issues stereo kernel columns to one SAD engine and re-emits its depth results.
// Optional WAIT_DONE watchdog enabled by defining SAD_SEQ_TIMEOUT_EN.
module sad_sequencer
  import sad_pkg::*;
#(
  parameter int KERNEL_WIDTH = 3,
  parameter int OFFSET       = 10,
  parameter int H_ACTIVE     = 320,
  parameter int V_ACTIVE     = 240
`ifdef SAD_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         col_valid_in,
  output logic                         col_ready_out,
  input  logic [KERNEL_WIDTH-1:0][7:0] left_col_in,
  input  logic [KERNEL_WIDTH-1:0][7:0] right_col_in,
  input  logic [HCOUNT_W-1:0]          hcount_in,
  input  logic [VCOUNT_W-1:0]          vcount_in,
  output logic                         sad_valid_out,
  output logic [KERNEL_WIDTH-1:0][7:0] sad_left_out,
  output logic [KERNEL_WIDTH-1:0][7:0] sad_right_out,
  output logic [HCOUNT_W-1:0]          sad_hcount_out,
  output logic [VCOUNT_W-1:0]          sad_vcount_out,
  input  logic                         sad_busy_in,
  input  logic                         sad_valid_in,
  input  logic [7:0]                   sad_line_in,
  output logic                         depth_valid_out,
  output logic [7:0]                   depth_out,
  output logic [HCOUNT_W-1:0]          depth_hcount_out,
  output logic [VCOUNT_W-1:0]          depth_vcount_out,
  output logic                         frame_done_out
`ifdef SAD_SEQ_TIMEOUT_EN
  , output logic                       timeout_err_out
`endif
);

  state_t r_state;
  state_t w_next;
  logic   w_accept;
  logic   w_result;
  logic   w_timeout;
  logic   w_warmup;
  logic   w_last_pix;

  assign w_accept = col_valid_in && col_ready_out;
  assign w_result = (r_state == WAIT_DONE) && sad_valid_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Ready is held low while reset is asserted so every output reads 0 in reset.
  always_comb begin
    w_next        = r_state;
    col_ready_out = 1'b0;
    sad_valid_out = 1'b0;
    unique case (r_state)
      IDLE: begin
        col_ready_out = !sad_busy_in && !rst_in;
        if (col_valid_in && !sad_busy_in && !rst_in) w_next = ISSUE;
      end
      ISSUE: begin
        sad_valid_out = 1'b1;
        w_next        = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (sad_valid_in || w_timeout) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sad_left_out     <= '0;
      sad_right_out    <= '0;
      sad_hcount_out   <= '0;
      sad_vcount_out   <= '0;
      depth_valid_out  <= 1'b0;
      depth_out        <= '0;
      depth_hcount_out <= '0;
      depth_vcount_out <= '0;
      frame_done_out   <= 1'b0;
    end else begin
      depth_valid_out <= 1'b0;
      frame_done_out  <= 1'b0;
      if (w_accept) begin
        sad_left_out   <= left_col_in;
        sad_right_out  <= right_col_in;
        sad_hcount_out <= hcount_in;
        sad_vcount_out <= vcount_in;
      end
      // Frame-done fires for the last pixel even when its depth is a warm-up drop.
      if (w_result) begin
        depth_out        <= sad_line_in;
        depth_hcount_out <= sad_hcount_out;
        depth_vcount_out <= sad_vcount_out;
        depth_valid_out  <= !w_warmup;
        frame_done_out   <= w_last_pix;
      end
    end
  end

`ifdef SAD_SEQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] r_timer;

  // An answer on the final allowed cycle still wins over the timeout.
  assign w_timeout = (r_state == WAIT_DONE) && !sad_valid_in && (r_timer == '0);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_timer         <= '0;
      timeout_err_out <= 1'b0;
    end else begin
      if (r_state == ISSUE) begin
        r_timer <= TMR_LOAD;
      end else if (r_state == WAIT_DONE && r_timer != '0) begin
        r_timer <= r_timer - TMR_W'(1);
      end
      if (w_timeout) timeout_err_out <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  sad_seq_row_tracker #(
    .KERNEL_WIDTH (KERNEL_WIDTH),
    .OFFSET       (OFFSET),
    .H_ACTIVE     (H_ACTIVE),
    .V_ACTIVE     (V_ACTIVE)
  ) u_row_tracker (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_accept   (w_accept),
    .i_hcount   (hcount_in),
    .i_vcount   (vcount_in),
    .o_warmup   (w_warmup),
    .o_last_pix (w_last_pix)
  );

endmodule
